spi_tx_fifo: RTL

SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_tx_fifo_if.sv | 28 ++
 rtl/spi_fifo_mem.sv | 33 +++
 rtl/spi_tx_fifo.sv | 95 +++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FIFO sizing defaults plus the mode and chip-select
// encodings used by the transmitter.
package spi_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int DEPTH_DEF  = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   typedef enum logic [1:0] {
      SPI_CS_NONE = 2'b11,
      SPI_CS_DEV0 = 2'b10,
      SPI_CS_DEV1 = 2'b01
   } spi_cs_e;

endpackage

// File: rtl/spi_tx_fifo_if.sv
// Host/transmitter-side bundle of the SPI TX FIFO; master drives strobes,
// slave (the FIFO) drives data and status.
interface spi_tx_fifo_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [WORD_W-1:0] wr_data;
   logic              rd_req;
   logic [WORD_W-1:0] rd_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              flush;
   logic              clear_err;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_req, flush, clear_err,
      input  rd_data, empty, full, level, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_req, flush, clear_err,
      output rd_data, empty, full, level, overflow, underflow
   );
endinterface

// File: rtl/spi_fifo_mem.sv
// 1-write/1-read register array with a registered read port; shared by the
// TX and RX FIFOs. Only the read register is reset, never the storage.
module spi_fifo_mem #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Read register holds between reads so the shifter sees a stable word.
   always_ff @(posedge clock) begin
      if (reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/spi_tx_fifo.sv
// Circular-buffer TX FIFO feeding the SPI transmitter: pointer/level control
// and sticky error flags around a spi_fifo_mem storage array.
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic           clock,
   input logic           reset,
   spi_tx_fifo_if.slave  bus
);

   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              is_empty;
   logic              is_full;
   logic              pop_ok;
   logic              push_ok;
   logic              overflow_evt;
   logic              underflow_evt;

   assign is_empty = (level_q == '0);
   assign is_full  = (level_q == FULL_LEVEL);

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
   assign pop_ok        = bus.rd_req && !is_empty && !bus.flush;
   assign push_ok       = bus.wr_en && (!is_full || pop_ok) && !bus.flush;
   assign overflow_evt  = bus.wr_en && !push_ok && !bus.flush;
   assign underflow_evt = bus.rd_req && is_empty && !bus.flush;

   // Pointer and occupancy bookkeeping; flush empties without touching rd_data.
   always_ff @(posedge clock) begin
      if (reset || bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Sticky errors: a fresh event outranks clear_err in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (overflow_evt)
            overflow_q <= 1'b1;
         else if (bus.clear_err)
            overflow_q <= 1'b0;
         if (underflow_evt)
            underflow_q <= 1'b1;
         else if (bus.clear_err)
            underflow_q <= 1'b0;
      end
   end

   spi_fifo_mem #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (push_ok && !reset),
      .wr_addr (wr_ptr),
      .wr_data (bus.wr_data),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr),
      .rd_data (bus.rd_data)
   );

   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule
